// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle RV32I controller (master) and its datapath (slave).
// Memory handshake: FETCH, MEMREAD and MEMWRITE present an access and hold it every cycle until
// mem_ready is high; the access completes in that cycle. mem_ready is ignored in all other states.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             zero;
  logic             neg;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [2:0]       imm_src;
  logic             reg_write;
  logic [CNT_W-1:0] instret;
  logic             trap;

  modport master (
    input  op, funct3, zero, neg, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, instret, trap
  );

  modport slave (
    output op, funct3, zero, neg, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, instret, trap
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-memory multi-cycle RV32I datapath, with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to make an illegal opcode lock in a trap state until reset.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus,
  output logic [3:0]              state_dbg
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECR     = 4'd6,
    EXECI     = 4'd7,
    LUI       = 4'd8,
    ALUWB     = 4'd9,
    BRANCH    = 4'd10,
    JAL       = 4'd11,
    JALR_LINK = 4'd12,
    JALR_PC   = 4'd13,
    ILLEGAL   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t           state, state_n;
  logic [CNT_W-1:0] instret_q;
  logic             taken;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  // A retire is any return to FETCH; ILLEGAL's NOP pass-through does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (state != FETCH && state != ILLEGAL && state_n == FETCH) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.neg;
      3'b101:  taken = !bus.neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (bus.op)
      OP_STORE: imm_src = 3'b001;
      OP_BR:    imm_src = 3'b010;
      OP_LUI:   imm_src = 3'b011;
      OP_JAL:   imm_src = 3'b100;
      default:  imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_n    = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    trap       = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_n = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_n = MEMADR;
          OP_R:              state_n = EXECR;
          OP_I:              state_n = EXECI;
          OP_BR:             state_n = BRANCH;
          OP_JAL:            state_n = JAL;
          OP_JALR:           state_n = JALR_LINK;
          OP_LUI:            state_n = LUI;
          default:           state_n = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_n   = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_n = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_n    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_n = FETCH;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_n   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_n   = ALUWB;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_n   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_n   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
        state_n   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_n   = ALUWB;
      end
      // Link is written before the PC update; rs1 is already safe in A, so rd == rs1 works.
      JALR_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        state_n    = JALR_PC;
      end
      JALR_PC: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_n    = FETCH;
      end
      ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        trap    = 1'b1;
        state_n = ILLEGAL;
`else
        state_n = FETCH;
`endif
      end
      default: state_n = FETCH;
    endcase
  end

  assign bus.pc_write   = pc_write;
  assign bus.adr_src    = adr_src;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.imm_src    = imm_src;
  assign bus.reg_write  = reg_write;
  assign bus.instret    = instret_q;
  assign bus.trap       = trap;
  assign state_dbg      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state/control-vector checks per instruction class.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_LUI = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
                         S_JALR_LINK = 4'd12, S_JALR_PC = 4'd13, S_ILLEGAL = 4'd14;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, trap}
  localparam logic [13:0] C_FETCH_RDY  = 14'b1_0_0_1_10_00_10_00_0_0;
  localparam logic [13:0] C_FETCH_WAIT = 14'b0_0_0_0_10_00_10_00_0_0;
  localparam logic [13:0] C_DECODE     = 14'b0_0_0_0_00_01_01_00_0_0;
  localparam logic [13:0] C_MEMADR     = 14'b0_0_0_0_00_10_01_00_0_0;
  localparam logic [13:0] C_MEMREAD    = 14'b0_1_0_0_00_00_00_00_0_0;
  localparam logic [13:0] C_MEMWB      = 14'b0_0_0_0_01_00_00_00_1_0;
  localparam logic [13:0] C_MEMWRITE   = 14'b0_1_1_0_00_00_00_00_0_0;
  localparam logic [13:0] C_EXECR      = 14'b0_0_0_0_00_10_00_10_0_0;
  localparam logic [13:0] C_EXECI      = 14'b0_0_0_0_00_10_01_10_0_0;
  localparam logic [13:0] C_LUI        = 14'b0_0_0_0_00_11_01_00_0_0;
  localparam logic [13:0] C_ALUWB      = 14'b0_0_0_0_00_00_00_00_1_0;
  localparam logic [13:0] C_BR_NT      = 14'b0_0_0_0_00_10_00_01_0_0;
  localparam logic [13:0] C_BR_T       = 14'b1_0_0_0_00_10_00_01_0_0;
  localparam logic [13:0] C_JAL        = 14'b1_0_0_0_00_01_10_00_0_0;
  localparam logic [13:0] C_JALR_LINK  = 14'b0_0_0_0_10_01_10_00_1_0;
  localparam logic [13:0] C_JALR_PC    = 14'b1_0_0_0_10_10_01_00_0_0;
  localparam logic [13:0] C_IDLE       = 14'b0_0_0_0_00_00_00_00_0_0;
  localparam logic [13:0] C_TRAP       = 14'b0_0_0_0_00_00_00_00_0_1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  state_dbg;
  logic [13:0] ctl_obs;
  int          n_checks;
  int          n_errors;
  int          exp_instret;

  multicycle_controller_if #(.CNT_W(32)) bus ();

  multicycle_controller #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  assign ctl_obs = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.trap};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (state_dbg !== S_FETCH || ctl_obs !== C_FETCH_WAIT || bus.instret !== 32'd0) begin
      n_errors++;
      $display("FAIL reset: state=%0d ctl=%b instret=%0d, expected state=%0d ctl=%b instret=0",
               state_dbg, ctl_obs, bus.instret, S_FETCH, C_FETCH_WAIT);
    end
    bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl_obs !== C_FETCH_RDY) begin
      n_errors++;
      $display("FAIL reset_ready_gate: ctl=%b expected %b", ctl_obs, C_FETCH_RDY);
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_instret = 0;
  endtask

  task automatic test_add();
    logic [3:0]  st [4];
    logic [13:0] cv [4];
    st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
    cv = '{C_FETCH_RDY, C_DECODE, C_EXECR, C_ALUWB};
    bus.op = 7'b0110011;
    bus.funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      #1;
      n_checks++;
      if (state_dbg !== st[i] || ctl_obs !== cv[i]) begin
        n_errors++;
        $display("FAIL add[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_dbg, ctl_obs, st[i], cv[i]);
      end
      tick();
    end
    exp_instret++;
    n_checks++;
    if (state_dbg !== S_FETCH || bus.instret !== exp_instret[31:0]) begin
      n_errors++;
      $display("FAIL add_retire: state=%0d instret=%0d, expected state=0 instret=%0d",
               state_dbg, bus.instret, exp_instret);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  st  [11];
    logic [13:0] cv  [11];
    logic        rdy [11];
    int          ir_pulses;
    st  = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
            S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
    cv  = '{C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_RDY, C_DECODE, C_MEMADR,
            C_MEMREAD, C_MEMREAD, C_MEMREAD, C_MEMREAD, C_MEMWB};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ir_pulses = 0;
    bus.op = 7'b0000011;
    bus.funct3 = 3'b010;
    for (int i = 0; i < 11; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      if (ctl_obs[10]) ir_pulses++;
      n_checks++;
      if (state_dbg !== st[i] || ctl_obs !== cv[i]) begin
        n_errors++;
        $display("FAIL lw[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_dbg, ctl_obs, st[i], cv[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (bus.imm_src !== 3'b000) begin
          n_errors++;
          $display("FAIL lw_imm_src: got %b expected 000", bus.imm_src);
        end
      end
      tick();
    end
    exp_instret++;
    n_checks++;
    if (ir_pulses != 1 || state_dbg !== S_FETCH || bus.instret !== exp_instret[31:0]) begin
      n_errors++;
      $display("FAIL lw_summary: ir_pulses=%0d state=%0d instret=%0d, expected 1, 0, %0d",
               ir_pulses, state_dbg, bus.instret, exp_instret);
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0]  st  [6];
    logic [13:0] cv  [6];
    logic        rdy [6];
    int          mw_cycles;
    st  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE, S_MEMWRITE};
    cv  = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMWRITE, C_MEMWRITE, C_MEMWRITE};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    mw_cycles = 0;
    bus.op = 7'b0100011;
    bus.funct3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      if (ctl_obs[11]) mw_cycles++;
      n_checks++;
      if (state_dbg !== st[i] || ctl_obs !== cv[i]) begin
        n_errors++;
        $display("FAIL sw[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_dbg, ctl_obs, st[i], cv[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (bus.imm_src !== 3'b001) begin
          n_errors++;
          $display("FAIL sw_imm_src: got %b expected 001", bus.imm_src);
        end
      end
      tick();
    end
    exp_instret++;
    n_checks++;
    if (mw_cycles != 3 || state_dbg !== S_FETCH || bus.instret !== exp_instret[31:0]) begin
      n_errors++;
      $display("FAIL sw_summary: mem_write_cycles=%0d state=%0d instret=%0d, expected 3, 0, %0d",
               mw_cycles, state_dbg, bus.instret, exp_instret);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3 [6];
    logic       z  [6];
    logic       n  [6];
    logic       tk [6];
    logic [3:0]  st [3];
    logic [13:0] cv [3];
    // beq taken, bne not taken, bne taken, blt taken, bge not taken, reserved funct3
    f3 = '{3'b000, 3'b001, 3'b001, 3'b100, 3'b101, 3'b010};
    z  = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1};
    n  = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
    tk = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};
    st = '{S_FETCH, S_DECODE, S_BRANCH};
    bus.op = 7'b1100011;
    for (int k = 0; k < 6; k++) begin
      bus.funct3 = f3[k];
      bus.zero = z[k];
      bus.neg = n[k];
      cv = '{C_FETCH_RDY, C_DECODE, tk[k] ? C_BR_T : C_BR_NT};
      for (int i = 0; i < 3; i++) begin
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (state_dbg !== st[i] || ctl_obs !== cv[i]) begin
          n_errors++;
          $display("FAIL branch%0d[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                   k, i, state_dbg, ctl_obs, st[i], cv[i]);
        end
        tick();
      end
      exp_instret++;
      n_checks++;
      if (bus.imm_src !== 3'b010 || bus.instret !== exp_instret[31:0]) begin
        n_errors++;
        $display("FAIL branch%0d_retire: imm_src=%b instret=%0d, expected 010 %0d",
                 k, bus.imm_src, bus.instret, exp_instret);
      end
    end
    bus.zero = 1'b0;
    bus.neg = 1'b0;
  endtask

  task automatic test_jal_lui_addi();
    logic [6:0]  ops  [3];
    logic [3:0]  s3   [3];
    logic [13:0] c3   [3];
    logic [2:0]  imms [3];
    logic [3:0]  st   [4];
    logic [13:0] cv   [4];
    ops  = '{7'b1101111, 7'b0110111, 7'b0010011};
    s3   = '{S_JAL, S_LUI, S_EXECI};
    c3   = '{C_JAL, C_LUI, C_EXECI};
    imms = '{3'b100, 3'b011, 3'b000};
    for (int k = 0; k < 3; k++) begin
      bus.op = ops[k];
      bus.funct3 = 3'b000;
      st = '{S_FETCH, S_DECODE, s3[k], S_ALUWB};
      cv = '{C_FETCH_RDY, C_DECODE, c3[k], C_ALUWB};
      for (int i = 0; i < 4; i++) begin
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (state_dbg !== st[i] || ctl_obs !== cv[i]) begin
          n_errors++;
          $display("FAIL op%0d[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                   k, i, state_dbg, ctl_obs, st[i], cv[i]);
        end
        tick();
      end
      exp_instret++;
      n_checks++;
      if (bus.imm_src !== imms[k] || bus.instret !== exp_instret[31:0]) begin
        n_errors++;
        $display("FAIL op%0d_retire: imm_src=%b instret=%0d, expected %b %0d",
                 k, bus.imm_src, bus.instret, imms[k], exp_instret);
      end
    end
  endtask

  task automatic test_jalr_reset();
    logic [3:0]  st [4];
    logic [13:0] cv [4];
    st = '{S_FETCH, S_DECODE, S_JALR_LINK, S_JALR_PC};
    cv = '{C_FETCH_RDY, C_DECODE, C_JALR_LINK, C_JALR_PC};
    bus.op = 7'b1100111;
    bus.funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      #1;
      n_checks++;
      if (state_dbg !== st[i] || ctl_obs !== cv[i]) begin
        n_errors++;
        $display("FAIL jalr[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_dbg, ctl_obs, st[i], cv[i]);
      end
      if (i < 3) tick();
    end
    // still in JALR_PC: reset aborts without counting a retire
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_instret = 0;
    n_checks++;
    if (state_dbg !== S_FETCH || bus.instret !== 32'd0 || ctl_obs !== C_FETCH_WAIT) begin
      n_errors++;
      $display("FAIL jalr_reset: state=%0d instret=%0d ctl=%b, expected 0 0 %b",
               state_dbg, bus.instret, ctl_obs, C_FETCH_WAIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (state_dbg !== S_FETCH || bus.instret !== 32'd0) begin
      n_errors++;
      $display("FAIL jalr_post_reset: state=%0d instret=%0d, expected 0 0",
               state_dbg, bus.instret);
    end
  endtask

  task automatic test_illegal();
    bus.op = 7'b1111111;
    bus.funct3 = 3'b000;
    bus.mem_ready = 1'b1;
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if (state_dbg !== S_ILLEGAL || ctl_obs !== C_TRAP) begin
        n_errors++;
        $display("FAIL trap[%0d]: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state_dbg, ctl_obs, S_ILLEGAL, C_TRAP);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    exp_instret = 0;
    n_checks++;
    if (state_dbg !== S_FETCH || ctl_obs !== C_FETCH_WAIT) begin
      n_errors++;
      $display("FAIL trap_exit: state=%0d ctl=%b, expected 0 %b", state_dbg, ctl_obs, C_FETCH_WAIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`else
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state_dbg !== S_ILLEGAL || ctl_obs !== C_IDLE) begin
      n_errors++;
      $display("FAIL illegal_nop: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state_dbg, ctl_obs, S_ILLEGAL, C_IDLE);
    end
    tick();
    n_checks++;
    if (state_dbg !== S_FETCH || bus.instret !== exp_instret[31:0]) begin
      n_errors++;
      $display("FAIL illegal_return: state=%0d instret=%0d, expected 0 %0d",
               state_dbg, bus.instret, exp_instret);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_instret = 0;
    rst_n = 1'b0;
    bus.op = 7'd0;
    bus.funct3 = 3'd0;
    bus.zero = 1'b0;
    bus.neg = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_stall();
    test_sw_stall();
    test_branch();
    test_jal_lui_addi();
    test_illegal();
    test_jalr_reset();
    test_add();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-memory, multi-cycle RV32I datapath: PC, IR/OldPC, A/B, ALUOut and Data registers, one ALU, one register file, one unified instruction/data memory.
- Decodes `op`/`funct3` of the latched instruction and drives every datapath enable and mux select.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter `instret`.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU result == 0
- neg  in  1  ALU result sign bit (signed compare)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC <= Result
- adr_src  out  1  memory address mux: 0 = PC, 1 = Result
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR <= ReadData, OldPC <= PC
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = A, 11 = zero
- alu_src_b  out  2  00 = B, 01 = ImmExt, 10 = constant 4
- alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
- reg_write  out  1  register file write enable
- instret  out  CNT_W  retired-instruction count
- trap  out  1  illegal-opcode indication (see Optional Feature)

Behaviour:
- Reset (async, `rst_n` = 0): state = FETCH, `instret` = 0.
  - All outputs are 0 except the FETCH values below, which are gated by `mem_ready`.
- Default per state: every output is 0 unless listed.
- `imm_src` is combinational from `op` in all states:
  - I-type / LW / JALR = 000, S = 001, B = 010, LUI = 011, JAL = 100.
  - Any other opcode = 000.
- FETCH
  - Outputs: `adr_src` = 0, `alu_src_a` = 00, `alu_src_b` = 10, `alu_op` = 00, `result_src` = 10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready` = 0; goes to DECODE on `mem_ready` = 1.
- DECODE
  - Outputs: `alu_src_a` = 01, `alu_src_b` = 01, `alu_op` = 00 (branch/JAL target into ALUOut).
  - Next state by `op`: 0000011 / 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR_LINK; 0110111 -> LUI; else -> ILLEGAL.
- MEMADR
  - Outputs: `alu_src_a` = 10, `alu_src_b` = 01, `alu_op` = 00.
  - Next: MEMREAD if `op` = 0000011, else MEMWRITE.
- MEMREAD
  - Outputs: `adr_src` = 1, `result_src` = 00.
  - Waits for `mem_ready`, then goes to MEMWB.
- MEMWB
  - Outputs: `result_src` = 01, `reg_write` = 1.
  - Next: FETCH.
- MEMWRITE
  - Outputs: `adr_src` = 1, `result_src` = 00.
  - `mem_write` = 1 held every cycle until `mem_ready` = 1, then FETCH.
- EXECR
  - Outputs: `alu_src_a` = 10, `alu_src_b` = 00, `alu_op` = 10.
  - Next: ALUWB.
- EXECI
  - Outputs: `alu_src_a` = 10, `alu_src_b` = 01, `alu_op` = 10.
  - Next: ALUWB.
- LUI
  - Outputs: `alu_src_a` = 11, `alu_src_b` = 01, `alu_op` = 00.
  - Next: ALUWB.
- ALUWB
  - Outputs: `result_src` = 00, `reg_write` = 1.
  - Next: FETCH.
- BRANCH
  - Outputs: `alu_src_a` = 10, `alu_src_b` = 00, `alu_op` = 01, `result_src` = 00.
  - `pc_write` = taken:
    - `funct3` 000 = `zero`; 001 = !`zero`; 100 = `neg`; 101 = !`neg`.
    - Other `funct3` values are not taken.
  - Next: FETCH.
- JAL
  - Outputs: `alu_src_a` = 01, `alu_src_b` = 10, `alu_op` = 00, `result_src` = 00, `pc_write` = 1.
  - Next: ALUWB (writes OldPC + 4 to rd).
- JALR_LINK
  - Outputs: `alu_src_a` = 01, `alu_src_b` = 10, `result_src` = 10, `reg_write` = 1.
  - Next: JALR_PC.
- JALR_PC
  - Outputs: `alu_src_a` = 10, `alu_src_b` = 01, `result_src` = 10, `pc_write` = 1.
  - Next: FETCH.
  - Correct when rd = rs1, because rs1 is held in the A register latched in DECODE.
- ILLEGAL: see Optional Feature.
- `instret`
  - Increments by 1 on every transition into FETCH from any state other than FETCH.
  - Wraps modulo 2^CNT_W.
  - Does not increment for ILLEGAL.
- Reset asserted mid-instruction aborts immediately. No partial retire is counted.
- `mem_ready` is ignored in states that do not access memory.
- `pc_write` and `ir_write` are the only outputs that depend on inputs other than `op`/`funct3`.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL asserts `trap` = 1 and holds there with all write enables at 0.
  - Exits only on reset.
- Undefined:
  - ILLEGAL is a one-cycle NOP: `trap` = 0, then FETCH.
  - `instret` is not incremented.

Test Plan:
- Reset, then `add` (op 0110011) with `mem_ready` = 1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH; `reg_write` = 1 only in ALUWB; `instret` = 1.
- `lw` with `mem_ready` low 3 cycles in both FETCH and MEMREAD -> `ir_write` pulses exactly once; MEMWB asserts `result_src` = 01 with `reg_write` = 1; total 11 cycles; `instret` = 1.
- `sw` with `mem_ready` = 0 for 2 cycles in MEMWRITE -> `mem_write` = 1 for 3 consecutive cycles, `adr_src` = 1 throughout.
- `bne` (`funct3` = 001), once with `zero` = 1 and once with `zero` = 0 -> `pc_write` = 0 then 1 in BRANCH; `blt` with `neg` = 1 -> `pc_write` = 1.
- `jalr` -> JALR_LINK has `reg_write` = 1 with `result_src` = 10; JALR_PC has `pc_write` = 1 with `alu_src_a` = 10; `rst_n` pulsed low in JALR_PC -> FETCH, `instret` = 0.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN: `trap` stays 1 for 20 cycles, no write enables; without it: returns to FETCH after 1 cycle, `instret` unchanged.
